// File: rtl/seq_mult_fx_if.sv
// Request/response bundle for the sequential fixed-point multiplier.
interface seq_mult_fx_if #(
    parameter int WIDTH = 18
);
    logic                   start;
    logic                   sgn;
    logic [WIDTH-1:0]       dataa;
    logic [WIDTH-1:0]       datab;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       result_fx;
    logic                   ovf;

    modport master (
        output start, sgn, dataa, datab,
        input  busy, done, product, result_fx, ovf
    );

    modport slave (
        input  start, sgn, dataa, datab,
        output busy, done, product, result_fx, ovf
    );
endinterface

// File: rtl/seq_mult_fx.sv
// Shift-add multiplier, one partial product per clock, with a rounded and
// saturated Q-format result next to the full-precision product.
module seq_mult_fx #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 16
) (
    input  logic           CLK,
    input  logic           RST,
    seq_mult_fx_if.slave   bus
);
    localparam int PW  = 2 * WIDTH;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
    // Half an LSB of the scaled result; zero when there is no fraction.
    localparam logic [PW:0] RND = (FRAC > 0) ? ({{PW{1'b0}}, 1'b1} << RSH) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         r_state;
    logic               r_sgn;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [PW-1:0]      r_product;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [PW-1:0]      w_mcand_sh;
    logic [PW-1:0]      w_p;
    logic [PW:0]        w_r;
    logic [PW:0]        w_s;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;

    // Magnitudes held unsigned in WIDTH bits so the most negative value stays exact.
    assign w_mag_a    = (bus.sgn & bus.dataa[WIDTH-1]) ? -bus.dataa : bus.dataa;
    assign w_mag_b    = (bus.sgn & bus.datab[WIDTH-1]) ? -bus.datab : bus.datab;
    assign w_mcand_sh = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_p        = r_neg ? -r_acc : r_acc;
    // One extra bit so the rounding add can never wrap.
    assign w_r        = {r_sgn & w_p[PW-1], w_p} + RND;

    // Scale down: arithmetic shift for signed operands, logical otherwise.
    always_comb begin
        if (r_sgn) w_s = $signed(w_r) >>> FRAC;
        else       w_s = w_r >> FRAC;
    end

    // Clamp to the WIDTH-bit result range; in range means the dropped bits are pure sign/zero.
    always_comb begin
        w_res = w_s[WIDTH-1:0];
        w_ovf = 1'b0;
        if (r_sgn) begin
            if (!w_s[PW] && (|w_s[PW-1:WIDTH-1])) begin
                w_res = {1'b0, {(WIDTH-1){1'b1}}};
                w_ovf = 1'b1;
            end else if (w_s[PW] && !(&w_s[PW-1:WIDTH-1])) begin
                w_res = {1'b1, {(WIDTH-1){1'b0}}};
                w_ovf = 1'b1;
            end
        end else if (|w_s[PW:WIDTH]) begin
            w_res = {WIDTH{1'b1}};
            w_ovf = 1'b1;
        end
    end

    // Control FSM and datapath: capture, WIDTH fixed iterations, then publish results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_sgn     <= 1'b0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sgn    <= bus.sgn;
                        r_neg    <= bus.sgn & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_mplier[r_cnt]) r_acc <= r_acc + w_mcand_sh;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIN;
                end
                S_FIN: begin
                    r_product <= w_p;
                    r_result  <= w_res;
                    r_ovf     <= w_ovf;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.product   = r_product;
    assign bus.result_fx = r_result;
    assign bus.ovf       = r_ovf;
endmodule
